// File: rtl/registered_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : registered_mux_arbiter
// Brief    : N-input registered mux with valid/ready handshake, explicit-select
//            or round-robin channel grant, and a single output pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
module registered_mux_arbiter #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SEL_W-1:0]     out_ch
);

    localparam int c_NP = 1 << SEL_W;

    logic [SEL_W-1:0] r_last;
    logic [c_NP-1:0]  w_vld_ext;
    logic             w_load_en;
    logic             w_sel_ok;
    logic             w_rr_vld;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_gnt_vld;
    logic [SEL_W-1:0] w_gnt_idx;
    logic [WIDTH-1:0] w_data;

    assign w_load_en = !out_valid || out_ready;

    // Padded to the full select range so any sel value indexes safely.
    always_comb begin
        w_vld_ext        = '0;
        w_vld_ext[N-1:0] = in_valid;
    end

    assign w_sel_ok = (int'(sel) < N) && w_vld_ext[sel];

    // Scan from the channel after the last one served, wrapping modulo N.
    always_comb begin
        int               v_idx;
        logic [SEL_W-1:0] v_sel;
        w_rr_vld = 1'b0;
        w_rr_idx = '0;
        for (int k = 1; k <= N; k++) begin
            v_idx = (int'(r_last) + k) % N;
            v_sel = SEL_W'(v_idx);
            if (!w_rr_vld && w_vld_ext[v_sel]) begin
                w_rr_vld = 1'b1;
                w_rr_idx = v_sel;
            end
        end
    end

    assign w_gnt_vld = mode ? w_rr_vld : w_sel_ok;
    assign w_gnt_idx = mode ? w_rr_idx : sel;

    always_comb begin
        in_ready = '0;
        w_data   = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt_idx == SEL_W'(i)) begin
                in_ready[i] = !rst && w_load_en && w_gnt_vld;
                w_data      = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            r_last    <= SEL_W'(N - 1);
        end else if (w_load_en) begin
            if (w_gnt_vld) begin
                out       <= w_data;
                out_ch    <= w_gnt_idx;
                out_valid <= 1'b1;
                r_last    <= w_gnt_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_registered_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_registered_mux_arbiter
// Brief    : Directed self-checking bench for registered_mux_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_registered_mux_arbiter;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SEL_W = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   ch [N];
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   out_ch;

    int checks = 0;
    int errors = 0;

    assign in_data = {ch[3], ch[2], ch[1], ch[0]};

    always #5 clk = ~clk;

    registered_mux_arbiter #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [SEL_W-1:0] sel_seq [4];
        logic [WIDTH-1:0] exp_out [4];
        logic [SEL_W-1:0] rr_seq  [6];
        sel_seq = '{2'd0, 2'd1, 2'd3, 2'd2};
        exp_out = '{32'd4, 32'd2, 32'd12, 32'd3};
        rr_seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst = 1'b1; mode = 1'b1; sel = '0; out_ready = 1'b1; in_valid = 4'hF;
        ch[0] = 32'd4; ch[1] = 32'd2; ch[2] = 32'd3; ch[3] = 32'd12;

        // Reset held two cycles with every channel valid
        cyc();
        cyc();
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out", out, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        rst = 1'b0;
        #1;
        chk("rr_first_grant", 32'(in_ready), 32'b0001);

        // Explicit select
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = sel_seq[i];
            cyc();
            chk("sel_out", out, exp_out[i]);
            chk("sel_out_ch", 32'(out_ch), 32'(sel_seq[i]));
            chk("sel_out_valid", 32'(out_valid), 32'd1);
        end
        sel = 2'd1; in_valid = 4'b1101;
        #1;
        chk("sel_invalid_ready", 32'(in_ready), 32'h0);
        cyc();
        chk("sel_invalid_drop", 32'(out_valid), 32'd0);
        chk("sel_invalid_hold", out, 32'd3);

        // Round-robin, starting after ch3 so the order begins at ch0
        in_valid = 4'hF; sel = 2'd3;
        cyc();
        chk("rr_prime", 32'(out_ch), 32'd3);
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("rr_out_ch", 32'(out_ch), 32'(rr_seq[i]));
            chk("rr_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 4'b0100; ch[2] = 32'd555;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rr_only2_ch", 32'(out_ch), 32'd2);
            chk("rr_only2_out", out, 32'd555);
        end

        // Backpressure: hold 555, then release with no bubble
        out_ready = 1'b0; in_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            cyc();
            chk("bp_out", out, 32'd555);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_last_kept", 32'(in_ready), 32'b1000);
        in_valid = 4'b0010; ch[1] = 32'd7;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'b0010);
        cyc();
        chk("bp_release_out", out, 32'd7);
        chk("bp_release_ch", 32'(out_ch), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd1);

        // Wrap-around and mode switch
        ch[1] = 32'd2; ch[2] = 32'd3;
        mode = 1'b0; sel = 2'd3; in_valid = 4'hF;
        cyc();
        chk("wrap_sel3", out, 32'd12);
        mode = 1'b1; in_valid = 4'b0101;
        cyc();
        chk("wrap_ch0", 32'(out_ch), 32'd0);
        chk("wrap_ch0_out", out, 32'd4);
        cyc();
        chk("wrap_ch2", 32'(out_ch), 32'd2);
        chk("wrap_ch2_out", out, 32'd3);

        // Reset while a word is held under backpressure
        out_ready = 1'b0;
        cyc();
        chk("mid_held", 32'(out_valid), 32'd1);
        rst = 1'b1;
        cyc();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out", out, 32'd0);
        chk("mid_rst_ch", 32'(out_ch), 32'd0);
        rst = 1'b0; in_valid = 4'h0; out_ready = 1'b1;
        cyc();
        chk("mid_not_delivered", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
